// File: rtl/aes_pkg.sv
// Shared types, key-size encoding and GF(2^8) helpers for the iterative AES decrypt core.
package aes_pkg;

  localparam logic [2:0] KEY_LEN_128 = 3'b001;
  localparam logic [2:0] KEY_LEN_192 = 3'b010;
  localparam logic [2:0] KEY_LEN_256 = 3'b100;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      else      acc = acc;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [3:0] nr_decode(input logic [2:0] kl);
    logic [3:0] nr;
    if (|(kl & KEY_LEN_256))      nr = NR_256;
    else if (|(kl & KEY_LEN_192)) nr = NR_192;
    else if (|(kl & KEY_LEN_128)) nr = NR_128;
    else                          nr = 4'd0;
    return nr;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last_round,
  output logic [127:0] o_state
);

  logic [127:0] w_shifted;
  logic [127:0] w_subbed;
  logic [127:0] w_keyed;
  logic [127:0] w_mixed;

  // Row r rotates right by r; byte index is 4*row + col.
  always_comb begin
    w_shifted = 128'd0;
    w_subbed  = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_shifted[8*(4*r+c) +: 8] = i_state[8*(4*r+((c-r+4)%4)) +: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      w_subbed[8*k +: 8] = inv_sbox(w_shifted[8*k +: 8]);
    end
  end

  assign w_keyed = w_subbed ^ i_round_key;

  always_comb begin
    w_mixed = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mixed[8*(4*r+c) +: 8] =
            gf_mul(8'h0e, w_keyed[8*(4*r+c) +: 8]) ^
            gf_mul(8'h0b, w_keyed[8*(4*((r+1)%4)+c) +: 8]) ^
            gf_mul(8'h0d, w_keyed[8*(4*((r+2)%4)+c) +: 8]) ^
            gf_mul(8'h09, w_keyed[8*(4*((r+3)%4)+c) +: 8]);
      end
    end
  end

  always_comb begin
    if (i_last_round) o_state = w_keyed;
    else              o_state = w_mixed;
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, round keys
// fetched from an external key store in descending order with a valid/stall handshake.
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [127:0]      ciphertext,
  input  logic [2:0]        key_len,
  input  logic [127:0]      subkey,
  input  logic              subkey_valid,
  output logic [ADDR_W-1:0] subkey_addr,
  output logic [127:0]      plaintext,
  output logic              ready
);

  state_e            r_state, w_state_nxt;
  logic [127:0]      r_ct, w_ct_nxt;
  logic [127:0]      r_pt, w_pt_nxt;
  logic              r_ready, w_ready_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_rounds_left, w_rounds_nxt;
  logic [3:0]        w_nr;
  logic              w_last_round;
  logic [127:0]      w_round_out;

  assign w_nr         = nr_decode(key_len);
  assign w_last_round = (r_rounds_left == 4'd1);

  aes_inv_round u_inv_round (
    .i_state      (r_pt),
    .i_round_key  (subkey),
    .i_last_round (w_last_round),
    .o_state      (w_round_out)
  );

  // Next-state logic; every register holds while subkey_valid is low.
  always_comb begin
    w_state_nxt  = r_state;
    w_ct_nxt     = r_ct;
    w_pt_nxt     = r_pt;
    w_ready_nxt  = r_ready;
    w_addr_nxt   = r_addr;
    w_rounds_nxt = r_rounds_left;
    case (r_state)
      IDLE: begin
        if (start && (|key_len)) begin
          w_ct_nxt     = ciphertext;
          w_addr_nxt   = ADDR_W'(w_nr);
          w_rounds_nxt = w_nr;
          w_ready_nxt  = 1'b0;
          w_state_nxt  = INIT;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      INIT: begin
        if (subkey_valid) begin
          w_pt_nxt    = r_ct ^ subkey;
          w_addr_nxt  = r_addr - ADDR_W'(1);
          w_state_nxt = ROUND;
        end else begin
          w_state_nxt = INIT;
        end
      end
      ROUND: begin
        if (subkey_valid) begin
          w_pt_nxt     = w_round_out;
          w_rounds_nxt = r_rounds_left - 4'd1;
          if (w_last_round) begin
            w_ready_nxt = 1'b1;
            w_addr_nxt  = {ADDR_W{1'b0}};
            w_state_nxt = IDLE;
          end else if (r_addr == {ADDR_W{1'b0}}) begin
            w_addr_nxt  = {ADDR_W{1'b0}};
          end else begin
            w_addr_nxt  = r_addr - ADDR_W'(1);
          end
        end else begin
          w_state_nxt = ROUND;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_ct          <= 128'd0;
      r_pt          <= 128'd0;
      r_ready       <= 1'b0;
      r_addr        <= {ADDR_W{1'b0}};
      r_rounds_left <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_ct          <= w_ct_nxt;
      r_pt          <= w_pt_nxt;
      r_ready       <= w_ready_nxt;
      r_addr        <= w_addr_nxt;
      r_rounds_left <= w_rounds_nxt;
    end
  end

  assign subkey_addr = r_addr;
  assign plaintext   = r_pt;
  assign ready       = r_ready;

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS-197 vectors, stall/protocol/reset sequences and
// random blocks whose ciphertext comes from a forward-cipher model.
module tb_aes_decrypt;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] ciphertext;
  logic [2:0]   key_len;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic [3:0]   subkey_addr;
  logic [127:0] plaintext;
  logic         ready;

  logic [127:0] ks [0:15];
  logic [7:0]   sbox [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [255:0] key;
    logic [2:0]   klen;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;
  vec_t vecs [3];

  aes_decrypt #(.ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ciphertext   (ciphertext),
    .key_len      (key_len),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_addr  (subkey_addr),
    .plaintext    (plaintext),
    .ready        (ready)
  );

  assign subkey = ks[subkey_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from its definition: brute-force field inverse, then the affine map.
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic int nr_of(input logic [2:0] kl);
    if (kl[2]) return 14;
    else if (kl[1]) return 12;
    else if (kl[0]) return 10;
    else return 0;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  function automatic logic [127:0] to_state(input logic [127:0] f);
    logic [127:0] s;
    s = 128'd0;
    for (int i = 0; i < 16; i++) s[8*(4*(i%4)+i/4) +: 8] = f[127-8*i -: 8];
    return s;
  endfunction

  // FIPS-197 key expansion; key is left-aligned, round keys stored in state layout.
  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    nk = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) begin
      ks[r] = 128'd0;
      if (r <= nr)
        for (int row = 0; row < 4; row++)
          for (int col = 0; col < 4; col++)
            ks[r][8*(4*row+col) +: 8] = w[4*r+col][31-8*row -: 8];
    end
  endtask

  // Forward cipher on a 4x4 byte matrix; blocks are FIPS byte strings.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [127:0] out;
    for (int i = 0; i < 16; i++) m[i%4][i/4] = pt[127-8*i -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sbox[m[r][(c+r)%4]];
        m = t;
        if (rd < nr) begin
          for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
              t[r][c] = gmul(8'h02, m[r][c]) ^ gmul(8'h03, m[(r+1)%4][c]) ^
                        m[(r+2)%4][c] ^ m[(r+3)%4][c];
          m = t;
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) m[r][c] = m[r][c] ^ ks[rd][8*(4*r+c) +: 8];
    end
    out = 128'd0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = m[i%4][i/4];
    return out;
  endfunction

  // mode 0: subkey_valid high; 1: high on odd edges only; 2: random.
  task automatic run(input string nm, input logic [255:0] key, input logic [2:0] klen,
                     input logic [127:0] ct, input logic [127:0] exp_pt, input int mode,
                     input bit pulse_busy, input int exp_lat);
    int nr, cnt, lat, exp_addr;
    bit v, done;
    logic [3:0]   prev_addr;
    logic [127:0] prev_pt;
    nr = nr_of(klen);
    expand(key, nr);
    ciphertext = to_state(ct);
    key_len = klen;
    start = 1'b1;
    subkey_valid = 1'b0;
    tick();
    start = 1'b0;
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_len = 3'($urandom());
    chk({nm, "/ready_clear"}, 128'(ready), 128'(0));
    chk({nm, "/addr_start"}, 128'(subkey_addr), 128'(nr));
    cnt = 0; lat = 0; done = 1'b0;
    for (int n = 1; n < 120 && !done; n++) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (n % 2 == 1);
      else v = 1'($urandom_range(0, 1));
      subkey_valid = v;
      if (pulse_busy && n == 3) begin
        start = 1'b1;
        key_len = 3'b001;
      end
      prev_addr = subkey_addr;
      prev_pt = plaintext;
      tick();
      start = 1'b0;
      if (v) begin
        cnt++;
      end else begin
        chk({nm, "/stall_addr"}, 128'(subkey_addr), 128'(prev_addr));
        chk({nm, "/stall_pt"}, plaintext, prev_pt);
      end
      exp_addr = (cnt >= nr) ? 0 : nr - cnt;
      chk({nm, "/addr"}, 128'(subkey_addr), 128'(exp_addr));
      chk({nm, "/ready"}, 128'(ready), 128'(cnt == nr + 1));
      if (ready) begin
        done = 1'b1;
        lat = n;
      end
    end
    subkey_valid = 1'b0;
    chk({nm, "/done"}, 128'(done), 128'(1));
    chk({nm, "/plaintext"}, plaintext, to_state(exp_pt));
    if (exp_lat >= 0) chk({nm, "/latency"}, 128'(lat), 128'(exp_lat));
  endtask

  logic [255:0] rkey;
  logic [127:0] rpt;
  logic [127:0] rct;
  logic [127:0] held_pt;
  logic [2:0]   rkl;
  int           rmode;
  int           rnr;

  initial begin
    vecs[0] = '{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, klen: 3'b001,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff, lat: 11};
    vecs[1] = '{key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, klen: 3'b010,
                ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                pt: 128'h00112233445566778899aabbccddeeff, lat: 13};
    vecs[2] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, klen: 3'b100,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                pt: 128'h00112233445566778899aabbccddeeff, lat: 15};

    reset = 1'b0; start = 1'b0; ciphertext = 128'd0; key_len = 3'b000; subkey_valid = 1'b0;
    for (int r = 0; r < 16; r++) ks[r] = 128'd0;
    build_sbox();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("reset/ready", 128'(ready), 128'(0));
    chk("reset/plaintext", plaintext, 128'd0);
    chk("reset/addr", 128'(subkey_addr), 128'(0));

    start = 1'b1; key_len = 3'b000; ciphertext = 128'hdeadbeef;
    repeat (3) tick();
    start = 1'b0;
    chk("keylen0/ready", 128'(ready), 128'(0));
    chk("keylen0/addr", 128'(subkey_addr), 128'(0));

    for (int i = 0; i < 3; i++) begin
      expand(vecs[i].key, nr_of(vecs[i].klen));
      chk($sformatf("model_fips%0d", i), encrypt(vecs[i].pt, nr_of(vecs[i].klen)), vecs[i].ct);
      run($sformatf("fips%0d", i), vecs[i].key, vecs[i].klen, vecs[i].ct, vecs[i].pt,
          0, (i == 1), vecs[i].lat);
    end

    run("stall", vecs[0].key, vecs[0].klen, vecs[0].ct, vecs[0].pt, 1, 1'b0, 21);

    held_pt = plaintext;
    start = 1'b1; key_len = 3'b000;
    repeat (2) tick();
    start = 1'b0;
    chk("keylen0_ready_held/ready", 128'(ready), 128'(1));
    chk("keylen0_ready_held/pt", plaintext, held_pt);

    rkey = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(rkey, 10);
    rct = encrypt(rpt, 10);
    run("b2b_first", vecs[0].key, vecs[0].klen, vecs[0].ct, vecs[0].pt, 0, 1'b0, 11);
    run("b2b_second", rkey, 3'b001, rct, rpt, 0, 1'b0, 11);

    expand(vecs[0].key, 10);
    ciphertext = to_state(vecs[0].ct); key_len = 3'b001; start = 1'b1;
    tick();
    start = 1'b0; subkey_valid = 1'b1;
    repeat (5) tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset/ready", 128'(ready), 128'(0));
    chk("async_reset/plaintext", plaintext, 128'd0);
    chk("async_reset/addr", 128'(subkey_addr), 128'(0));
    tick();
    reset = 1'b1;
    subkey_valid = 1'b0;
    tick();
    chk("after_reset/addr", 128'(subkey_addr), 128'(0));
    run("post_reset", vecs[0].key, vecs[0].klen, vecs[0].ct, vecs[0].pt, 0, 1'b0, 11);

    for (int i = 0; i < 8; i++) begin
      rkl   = 3'($urandom_range(1, 7));
      rnr   = nr_of(rkl);
      rkey  = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      rpt   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rmode = $urandom_range(0, 2);
      expand(rkey, rnr);
      rct = encrypt(rpt, rnr);
      run($sformatf("rand%0d", i), rkey, rkl, rct, rpt, rmode, 1'($urandom_range(0, 1)),
          (rmode == 0) ? rnr + 1 : ((rmode == 1) ? 2*rnr + 1 : -1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
